// File: rtl/chacha_block_seq.sv
// ChaCha block sequencer: owns the 16-word state, drives an external
// combinational quarter-round step unit one step per cycle, and returns
// the permuted block (optionally with the feed-forward add).
module chacha_block_seq #(
  parameter int unsigned ROUNDS  = 20,
  parameter int unsigned FEEDFWD = 1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
  output logic [63:0]  qr_rs1,
  output logic [63:0]  qr_rs2,
  output logic         qr_op_ad0,
  output logic         qr_op_bc0,
  output logic         qr_op_ad1,
  output logic         qr_op_bc1,
  input  logic [63:0]  qr_rd
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NWORDS  = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned NDR     = ROUNDS / 2;
  localparam int unsigned DR_W    = (NDR > 1) ? $clog2(NDR) : 1;
  localparam logic [DR_W-1:0] LAST_DR = DR_W'(NDR - 1);

  typedef enum logic [1:0] {IDLE, RUN, FEED, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         step, step_nxt;
  logic [2:0]         qr, qr_nxt;
  logic [DR_W-1:0]    dr, dr_nxt;
  logic [WORD_W-1:0]  work     [NWORDS];
  logic [WORD_W-1:0]  work_nxt [NWORDS];
  logic [WORD_W-1:0]  saved    [NWORDS];
  logic [511:0]       work_flat_nxt;
  logic [IDX_W-1:0]   idx_a, idx_b, idx_c, idx_d;

  // Word selection: columns for qr 0..3, diagonals (rotated rows) for qr 4..7
  always_comb begin
    idx_a = {2'b00, qr[1:0]};
    idx_b = {2'b01, qr[1:0]};
    idx_c = {2'b10, qr[1:0]};
    idx_d = {2'b11, qr[1:0]};
    if (qr[2]) begin
      idx_b = {2'b01, qr[1:0] + 2'd1};
      idx_c = {2'b10, qr[1:0] + 2'd2};
      idx_d = {2'b11, qr[1:0] + 2'd3};
    end
  end

  // Next-state, step issue and work-register write-back
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    qr_nxt    = qr;
    dr_nxt    = dr;
    for (int i = 0; i < NWORDS; i++) work_nxt[i] = work[i];
    qr_rs1    = '0;
    qr_rs2    = '0;
    qr_op_ad0 = 1'b0;
    qr_op_bc0 = 1'b0;
    qr_op_ad1 = 1'b0;
    qr_op_bc1 = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = RUN;
          step_nxt  = '0;
          qr_nxt    = '0;
          dr_nxt    = '0;
          for (int i = 0; i < NWORDS; i++) work_nxt[i] = in_state[WORD_W*i +: WORD_W];
        end
      end
      RUN: begin
        qr_rs1    = {work[idx_a], work[idx_d]};
        qr_rs2    = {work[idx_b], work[idx_c]};
        qr_op_ad0 = (step == 2'd0);
        qr_op_bc0 = (step == 2'd1);
        qr_op_ad1 = (step == 2'd2);
        qr_op_bc1 = (step == 2'd3);
        for (int i = 0; i < NWORDS; i++) begin
          if (!step[0]) begin
            if (IDX_W'(i) == idx_a) work_nxt[i] = qr_rd[63:32];
            if (IDX_W'(i) == idx_d) work_nxt[i] = qr_rd[31:0];
          end else begin
            if (IDX_W'(i) == idx_b) work_nxt[i] = qr_rd[63:32];
            if (IDX_W'(i) == idx_c) work_nxt[i] = qr_rd[31:0];
          end
        end
        step_nxt = step + 2'd1;
        if (step == 2'd3) begin
          qr_nxt = qr + 3'd1;
          if (qr == 3'd7) begin
            dr_nxt = dr + DR_W'(1);
            if (dr == LAST_DR) begin
              dr_nxt    = '0;
              state_nxt = (FEEDFWD != 0) ? FEED : DONE;
            end
          end
        end
      end
      FEED: begin
        for (int i = 0; i < NWORDS; i++) work_nxt[i] = work[i] + saved[i];
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flatten the next work state for the output capture
  always_comb begin
    work_flat_nxt = '0;
    for (int i = 0; i < NWORDS; i++) work_flat_nxt[WORD_W*i +: WORD_W] = work_nxt[i];
  end

  // State, counters and work/saved registers
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
      step  <= '0;
      qr    <= '0;
      dr    <= '0;
      for (int i = 0; i < NWORDS; i++) begin
        work[i]  <= '0;
        saved[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      qr    <= qr_nxt;
      dr    <= dr_nxt;
      for (int i = 0; i < NWORDS; i++) work[i] <= work_nxt[i];
      if (state == IDLE && in_valid) begin
        for (int i = 0; i < NWORDS; i++) saved[i] <= in_state[WORD_W*i +: WORD_W];
      end
    end
  end

  // Registered handshake flags; result captured once on entry to DONE
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_state <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (state_nxt == DONE && state != DONE) out_state <= work_flat_nxt;
    end
  end

endmodule
